// File: rtl/qdr_user_arbiter.sv
// Two-client round-robin arbiter in front of a QDR controller user port.
// Tracks outstanding reads in an in-order tag FIFO and routes returned data to the issuing client.
module qdr_user_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 72,
  parameter int BE_WIDTH   = 8,
  parameter int TAG_DEPTH  = 16,
  localparam int N = $clog2(TAG_DEPTH)
) (
  input  logic                  clk0,
  input  logic                  reset,
  input  logic                  phy_rdy,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_we,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  input  logic [BE_WIDTH-1:0]   m0_wr_be,
  input  logic [BE_WIDTH-1:0]   m1_wr_be,
  output logic                  m0_ack,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m0_rd_dvld,
  output logic                  m1_rd_dvld,
  output logic [ADDR_WIDTH-1:0] usr_addr,
  output logic                  usr_wr_strb,
  output logic [DATA_WIDTH-1:0] usr_wr_data,
  output logic [BE_WIDTH-1:0]   usr_wr_be,
  output logic                  usr_rd_strb,
  input  logic [DATA_WIDTH-1:0] usr_rd_data,
  input  logic                  usr_rd_dvld,
  output logic [N:0]            rd_outstanding,
  output logic                  orphan_err
);

  // Handshake: a client holds mX_req and its fields stable until the cycle in which
  // mX_ack is high; that cycle is the transfer, and the command appears on usr_* one cycle later.

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [N-1:0]         wr_ptr;
  logic [N-1:0]         rd_ptr;
  logic                 last;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 elig0;
  logic                 elig1;
  logic                 grant;
  logic                 gnt_we;
  logic                 push;
  logic                 pop;
  logic                 head;

  assign tag_full  = (rd_outstanding == (N+1)'(TAG_DEPTH));
  assign tag_empty = (rd_outstanding == '0);

  assign elig0 = m0_req & phy_rdy & (m0_we | ~tag_full);
  assign elig1 = m1_req & phy_rdy & (m1_we | ~tag_full);

  // last == 1 means requester 1 was granted most recently, so requester 0 wins a tie.
  assign m0_ack = elig0 & (~elig1 | last);
  assign m1_ack = elig1 & (~elig0 | ~last);

  assign grant  = m0_ack | m1_ack;
  assign gnt_we = m1_ack ? m1_we : m0_we;
  assign push   = grant & ~gnt_we;
  assign pop    = usr_rd_dvld & ~tag_empty;
  assign head   = tag_mem[rd_ptr];

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      usr_addr       <= '0;
      usr_wr_data    <= '0;
      usr_wr_be      <= '0;
      usr_wr_strb    <= 1'b0;
      usr_rd_strb    <= 1'b0;
      m0_rd_data     <= '0;
      m1_rd_data     <= '0;
      m0_rd_dvld     <= 1'b0;
      m1_rd_dvld     <= 1'b0;
      rd_outstanding <= '0;
      orphan_err     <= 1'b0;
      tag_mem        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      last           <= 1'b1;
    end else begin
      usr_wr_strb <= grant & gnt_we;
      usr_rd_strb <= grant & ~gnt_we;
      if (grant) begin
        usr_addr    <= m1_ack ? m1_addr    : m0_addr;
        usr_wr_data <= m1_ack ? m1_wr_data : m0_wr_data;
        usr_wr_be   <= m1_ack ? m1_wr_be   : m0_wr_be;
        last        <= m1_ack;
      end

      if (push) begin
        tag_mem[wr_ptr] <= m1_ack;
        wr_ptr          <= wr_ptr + N'(1);
      end

      // Returned data is broadcast; only the owning client's valid pulses.
      m0_rd_dvld <= pop & ~head;
      m1_rd_dvld <= pop & head;
      if (pop) begin
        m0_rd_data <= usr_rd_data;
        m1_rd_data <= usr_rd_data;
        rd_ptr     <= rd_ptr + N'(1);
      end

      if (usr_rd_dvld && tag_empty) orphan_err <= 1'b1;

      case ({push, pop})
        2'b10:   rd_outstanding <= rd_outstanding + (N+1)'(1);
        2'b01:   rd_outstanding <= rd_outstanding - (N+1)'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_qdr_user_arbiter.sv
// Bench for qdr_user_arbiter: vector table with expected acks, plus a scoreboard
// that predicts the registered usr_* commands, read routing, outstanding count and orphan flag.
module tb_qdr_user_arbiter;

  localparam int AW = 21;
  localparam int DW = 72;
  localparam int BW = 8;
  localparam int TD = 4;
  localparam int N  = 2;
  localparam int CW = 1 + AW + DW + BW;

  logic          clk0;
  logic          reset;
  logic          phy_rdy;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data;
  logic [BW-1:0] m0_wr_be, m1_wr_be;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          m0_rd_dvld, m1_rd_dvld;
  logic [AW-1:0] usr_addr;
  logic          usr_wr_strb, usr_rd_strb;
  logic [DW-1:0] usr_wr_data;
  logic [BW-1:0] usr_wr_be;
  logic [DW-1:0] usr_rd_data;
  logic          usr_rd_dvld;
  logic [N:0]    rd_outstanding;
  logic          orphan_err;

  qdr_user_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_DEPTH(TD)
  ) dut (
    .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_wr_be(m0_wr_be), .m1_wr_be(m1_wr_be),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
    .m0_rd_dvld(m0_rd_dvld), .m1_rd_dvld(m1_rd_dvld),
    .usr_addr(usr_addr), .usr_wr_strb(usr_wr_strb), .usr_wr_data(usr_wr_data),
    .usr_wr_be(usr_wr_be), .usr_rd_strb(usr_rd_strb),
    .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
    .rd_outstanding(rd_outstanding), .orphan_err(orphan_err)
  );

  // clock / reset
  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    logic          phy;
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic          dv;
    logic          e0;
    logic          e1;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // scoreboard state
  logic [CW-1:0] exp_q[$];
  logic [DW:0]   rd_q[$];
  logic          tag_m[$];
  int            out_m = 0;
  logic          orphan_m = 1'b0;
  logic [CW-1:0] last_cmd = '0;

  vec_t tbl[$];

  function automatic vec_t mk(logic phy, logic r0, logic w0, logic [AW-1:0] a0,
                              logic r1, logic w1, logic [AW-1:0] a1,
                              logic dv, logic e0, logic e1);
    vec_t v;
    v.phy = phy; v.r0 = r0; v.w0 = w0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.dv = dv; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_strb"}, usr_wr_strb, 0);
    check({tag, "_rd_strb"}, usr_rd_strb, 0);
    check({tag, "_addr"}, usr_addr, 0);
    check({tag, "_wr_data"}, usr_wr_data, 0);
    check({tag, "_wr_be"}, usr_wr_be, 0);
    check({tag, "_m0_rd_data"}, m0_rd_data, 0);
    check({tag, "_m1_rd_data"}, m1_rd_data, 0);
    check({tag, "_m0_rd_dvld"}, m0_rd_dvld, 0);
    check({tag, "_m1_rd_dvld"}, m1_rd_dvld, 0);
    check({tag, "_outstanding"}, rd_outstanding, 0);
    check({tag, "_orphan"}, orphan_err, 0);
  endtask

  task automatic drive_idle();
    phy_rdy = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
    m0_wr_be = '0; m1_wr_be = '0; usr_rd_data = '0; usr_rd_dvld = 1'b0;
  endtask

  // Called at posedge+1; drives one cycle, checks acks mid-cycle and registered outputs after the edge.
  task automatic apply(input vec_t v);
    logic [DW-1:0] d0, d1, rdd;
    logic [BW-1:0] b0, b1;
    logic [CW-1:0] c;
    logic [DW:0]   r;
    logic          is_rd;
    logic          id;
    d0  = {32'($urandom), 32'($urandom), 8'($urandom)};
    d1  = {32'($urandom), 32'($urandom), 8'($urandom)};
    rdd = {32'($urandom), 32'($urandom), 8'($urandom)};
    b0  = 8'($urandom);
    b1  = 8'($urandom);
    phy_rdy = v.phy;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wr_data = d0; m0_wr_be = b0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wr_data = d1; m1_wr_be = b1;
    usr_rd_dvld = v.dv; usr_rd_data = rdd;
    #1;
    check("m0_ack", m0_ack, v.e0);
    check("m1_ack", m1_ack, v.e1);
    // pop sees the FIFO as it stood at the start of the cycle
    if (v.dv) begin
      if (tag_m.size() > 0) begin
        id = tag_m.pop_front();
        rd_q.push_back({id, rdd});
        out_m--;
      end else begin
        orphan_m = 1'b1;
      end
    end
    if (v.e0) begin
      exp_q.push_back({v.w0, v.a0, d0, b0});
      if (!v.w0) begin tag_m.push_back(1'b0); out_m++; end
    end
    if (v.e1) begin
      exp_q.push_back({v.w1, v.a1, d1, b1});
      if (!v.w1) begin tag_m.push_back(1'b1); out_m++; end
    end
    @(posedge clk0);
    #1;
    if (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      is_rd = !c[CW-1];
      check("usr_wr_strb", usr_wr_strb, c[CW-1]);
      check("usr_rd_strb", usr_rd_strb, is_rd);
      last_cmd = c;
    end else begin
      check("usr_wr_strb_idle", usr_wr_strb, 0);
      check("usr_rd_strb_idle", usr_rd_strb, 0);
    end
    check("usr_addr", usr_addr, last_cmd[CW-2 -: AW]);
    check("usr_wr_data", usr_wr_data, last_cmd[BW +: DW]);
    check("usr_wr_be", usr_wr_be, last_cmd[BW-1:0]);
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      is_rd = !r[DW];
      check("m0_rd_dvld", m0_rd_dvld, is_rd);
      check("m1_rd_dvld", m1_rd_dvld, r[DW]);
      if (r[DW]) check("m1_rd_data", m1_rd_data, r[DW-1:0]);
      else       check("m0_rd_data", m0_rd_data, r[DW-1:0]);
    end else begin
      check("m0_rd_dvld_idle", m0_rd_dvld, 0);
      check("m1_rd_dvld_idle", m1_rd_dvld, 0);
    end
    check("rd_outstanding", rd_outstanding, 128'(out_m));
    check("orphan_err", orphan_err, orphan_m);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk0);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // phy not ready: nothing granted even with both requesting
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 1, 'h10, 1, 1, 'h20, 0, 0, 0));
    // phy ready: tie alternates starting with m0
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 1, 'h10, 1, 1, 'h20, 0, (i % 2) == 0, (i % 2) == 1));
    tbl.push_back(mk(1, 0, 1, 'h30, 1, 1, 'h40, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 'h50, 0, 1, 'h40, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 'h60, 1, 1, 'h70, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // reads A (m0), B (m1), C (m0), returned after 8 idle cycles
    tbl.push_back(mk(1, 1, 0, 'hA, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 'hB, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 'hC, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // tag FIFO fills at 4; writes still pass; one return frees a slot
    for (int i = 0; i < 4; i++) apply(mk(1, 1, 0, AW'('h100 + i), 0, 0, 0, 0, 1, 0));
    apply(mk(1, 1, 0, 'h104, 1, 1, 'h200, 0, 0, 1));
    apply(mk(1, 1, 0, 'h104, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 1, 0, 'h104, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 1, 0, 'h104, 0, 0, 0, 0, 1, 0));
    apply(mk(1, 1, 0, 'h105, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 1, 0, 'h105, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // orphan return sets a sticky flag
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 1, 1, 'h2A, 0, 0, 0, 0, 1, 0));

    // two reads outstanding (last grant to m0), then async reset mid-cycle
    apply(mk(1, 0, 0, 0, 1, 0, 'h300, 0, 0, 1));
    apply(mk(1, 1, 0, 'h301, 0, 0, 0, 0, 1, 0));
    m0_req = 1'b0; m1_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete(); rd_q.delete(); tag_m.delete();
    out_m = 0; orphan_m = 1'b0; last_cmd = '0;
    @(posedge clk0);
    #1;
    reset = 1'b0;
    apply(mk(1, 1, 1, 'h400, 1, 1, 'h500, 0, 1, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qdr_user_arbiter.md
# qdr_user_arbiter

Two-requester round-robin arbiter in front of one QDR controller user port (72-bit burst word, 21-bit address). It multiplexes read and write commands from two independent clients onto the controller's single strobe interface and issues nothing until the PHY reports ready. It tracks outstanding reads in an in-order tag FIFO and routes each returned read word to the client that issued it. It sits between the QDR controller wrapper and the application logic, all on the controller's `clk0` domain.

## Interface

Parameters:
- `ADDR_WIDTH`, 21: user address width.
- `DATA_WIDTH`, 72: user data width (one burst-of-4 pair).
- `BE_WIDTH`, 8: byte-enable width.
- `TAG_DEPTH`, 16: maximum outstanding reads; power of 2, 2 to 64.

Ports (`N` = log2(`TAG_DEPTH`)):
- `clk0` in 1: single clock. All logic runs on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `phy_rdy` in 1: controller calibration done.
- `m0_req`, `m1_req` in 1: command request. Held with its fields until the matching ack.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in `ADDR_WIDTH`: command address.
- `m0_wr_data`, `m1_wr_data` in `DATA_WIDTH`: write data.
- `m0_wr_be`, `m1_wr_be` in `BE_WIDTH`: write byte enables.
- `m0_ack`, `m1_ack` out 1: combinational grant. The command is accepted in this cycle.
- `m0_rd_data`, `m1_rd_data` out `DATA_WIDTH`: returned read word.
- `m0_rd_dvld`, `m1_rd_dvld` out 1: read word valid for that requester.
- `usr_addr` out `ADDR_WIDTH`: address to controller.
- `usr_wr_strb` out 1: write strobe to controller.
- `usr_wr_data` out `DATA_WIDTH`: write data to controller.
- `usr_wr_be` out `BE_WIDTH`: byte enables to controller.
- `usr_rd_strb` out 1: read strobe to controller.
- `usr_rd_data` in `DATA_WIDTH`: read data from controller.
- `usr_rd_dvld` in 1: read data valid from controller.
- `rd_outstanding` out `N+1`: reads issued but not yet returned.
- `orphan_err` out 1: sticky flag. Set when read data returns with no outstanding tag.

## Operation

- Per requester X, eligibility `elig_X = mX_req & phy_rdy & (mX_we | ~tag_full)`, where `tag_full` means `rd_outstanding == TAG_DEPTH`.
- Arbitration, one grant per cycle at most:
  - Only one requester eligible: it wins.
  - Both eligible: the requester not granted most recently wins.
  - The `last` pointer updates only on a grant. On reset, `last` = 1, so requester 0 wins the first tie.
- `mX_ack = elig_X & win_X`, combinational from registered state and the inputs.
- On a grant, the winner's fields are registered onto `usr_*` and exactly one of `usr_wr_strb` / `usr_rd_strb` pulses for one cycle. With no grant, both strobes are 0; `usr_addr`, `usr_wr_data` and `usr_wr_be` hold their last values.
- Read grant pushes the winner's ID (1 bit) into the tag FIFO.
- Each `usr_rd_dvld` pops the FIFO head:
  - `usr_rd_data` is registered onto both `m0_rd_data` and `m1_rd_data`.
  - Only `m<head>_rd_dvld` pulses.
- `usr_rd_dvld` with the FIFO empty sets `orphan_err`, the data is dropped, and no `mX_rd_dvld` pulses. Only `reset` clears `orphan_err`.
- Push and pop in the same cycle: `rd_outstanding` is unchanged and both operations take effect.
- A read is refused when `tag_full` is set at the start of the cycle, even if a pop occurs in that same cycle. Writes are unaffected by `tag_full`.
- When `phy_rdy` drops: no new grants are made. Outstanding reads still return and are routed normally.
- Reset values:
  - `usr_wr_strb`, `usr_rd_strb`, `usr_addr`, `usr_wr_data`, `usr_wr_be`: 0.
  - `m*_rd_data`, `m*_rd_dvld`: 0.
  - `rd_outstanding`, `orphan_err`: 0.
  - FIFO empty, `last` = 1.
  - Reset mid-operation discards all outstanding tags. Later returns then set `orphan_err`.

## Timing

- Ack in cycle T -> `usr_*` strobe and fields valid in T+1. Command latency is 1 cycle.
- `usr_rd_dvld` in cycle T -> `mX_rd_data` / `mX_rd_dvld` in T+1. Return latency is 1 cycle.
- `rd_outstanding` is registered. It reflects the push/pop of cycle T from T+1.
- Throughput: one command per cycle in aggregate.
  - A single requester holding `req` high receives ack every cycle.
  - With both requesters continuously requesting, acks strictly alternate 0,1,0,1.
- Requester handshake: `req` and fields are sampled in the ack cycle. The requester changes them only after an ack cycle, or drops `req` when done.

## Test plan

- Reset, `phy_rdy` = 0, both `req` = 1 for 10 cycles -> no ack, no strobe. Raise `phy_rdy` -> `m0_ack` in that cycle, `usr_*` strobe next cycle.
- Both requesters issue continuous writes, addrs 0x10/0x20 -> acks alternate starting with 0. `usr_addr` sequence is 0x10, 0x20, 0x10, …, with `usr_wr_strb` high every cycle.
- m0 reads A, m1 reads B, m0 reads C. Controller returns D1, D2, D3 after 8 cycles -> `m0_rd_dvld` on D1 and D3, `m1_rd_dvld` on D2, each 1 cycle after `usr_rd_dvld`.
- `TAG_DEPTH` = 4, m0 issues 6 reads with no returns -> 4 acks, then stalled with `rd_outstanding` = 4. A write from m1 is acked meanwhile. One return -> next read acked in the cycle after the pop.
- `usr_rd_dvld` pulsed with no outstanding reads -> `orphan_err` = 1, no `mX_rd_dvld`, and the flag stays set until `reset`.
- 2 reads outstanding, assert `reset` asynchronously -> all outputs 0 immediately, `rd_outstanding` = 0, and the next arbitration tie goes to m0.
